// File: rtl/sayac_param.sv
// -----------------------------------------------------------------------------
// sayac_param -- parametrised up/down counter with built-in clock-enable
// prescaler. Everything runs on the board clock; the prescaler produces a
// one-cycle step enable that advances the counter.
//
// Optional feature macro: SAYAC_SATURATE_EN
//   defined   -> saturating mode (hold at the limits, tc on attempted overflow)
//   undefined -> modulo wrap (MODULO-1 <-> 0, tc on the wrap step)
//
// Parameters
//   WIDTH     counter width in bits
//   MODULO    count range 0..MODULO-1, 2 <= MODULO <= 2**WIDTH
//   PRESCALE  clk cycles per count step, >= 1 (1 = step on every edge)
//
// Ports
//   clk           system clock, all logic on the rising edge
//   rst           synchronous active-high reset
//   en            1 runs prescaler and counter, 0 freezes both
//   yon           direction, 1 = up, 0 = down (only matters on step edges)
//   load          synchronous load strobe, wins over stepping
//   load_val      value to load, clamped to MODULO-1
//   sayac_degeri  registered count value
//   adim          registered one-cycle pulse for every count step
//   tc            registered one-cycle pulse for a wrap/limit step
// -----------------------------------------------------------------------------
module sayac_param #(
  parameter int WIDTH    = 4,
  parameter int MODULO   = 16,
  parameter int PRESCALE = 50_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             yon,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] sayac_degeri,
  output logic             adim,
  output logic             tc
);

  // Prescaler width: $clog2(PRESCALE), but never narrower than one bit so
  // that PRESCALE=1 still has a (constant-zero) phase register.
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [PW-1:0]    PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [PW-1:0]    PRESC_ZERO = {PW{1'b0}};
  localparam logic [PW-1:0]    PRESC_ONE  = PW'(1);
  localparam logic [WIDTH:0]   MOD_EXT    = (WIDTH + 1)'(MODULO);
  localparam logic [WIDTH:0]   ONE_EXT    = (WIDTH + 1)'(1);
  localparam logic [WIDTH-1:0] CNT_MAX    = WIDTH'(MODULO - 1);
  localparam logic [WIDTH-1:0] CNT_ZERO   = {WIDTH{1'b0}};

  // Elaboration-time parameter legality checks.
  if (MODULO < 2 || MODULO > (2 ** WIDTH)) begin : g_bad_modulo
    $error("sayac_param: MODULO must satisfy 2 <= MODULO <= 2**WIDTH");
  end
  if (PRESCALE < 1) begin : g_bad_prescale
    $error("sayac_param: PRESCALE must be >= 1");
  end

  // ---------------------------------------------------------------------------
  // Helper functions. Arithmetic is done in WIDTH+1 bits so that
  // MODULO = 2**WIDTH compares and increments without overflow artefacts.
  // The step helpers return {limit_hit, next_value}.
  // ---------------------------------------------------------------------------

  // Clamp an out-of-range load value to the top of the count range.
  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    if ({1'b0, v} >= MOD_EXT) begin
      r = CNT_MAX;
    end else begin
      r = v;
    end
    return r;
  endfunction

  // One step upwards: wrap or saturate at MODULO-1.
  function automatic logic [WIDTH:0] step_up(input logic [WIDTH-1:0] v);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] r;
    sum = {1'b0, v} + ONE_EXT;
    if (sum >= MOD_EXT) begin
`ifdef SAYAC_SATURATE_EN
      r = {1'b1, CNT_MAX};
`else
      r = {1'b1, CNT_ZERO};
`endif
    end else begin
      r = {1'b0, sum[WIDTH-1:0]};
    end
    return r;
  endfunction

  // One step downwards: wrap or saturate at 0.
  function automatic logic [WIDTH:0] step_down(input logic [WIDTH-1:0] v);
    logic [WIDTH:0] diff;
    logic [WIDTH:0] r;
    diff = {1'b0, v} - ONE_EXT;
    if (v == CNT_ZERO) begin
`ifdef SAYAC_SATURATE_EN
      r = {1'b1, CNT_ZERO};
`else
      r = {1'b1, CNT_MAX};
`endif
    end else begin
      r = {1'b0, diff[WIDTH-1:0]};
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [PW-1:0]    presc_cnt;
  logic [WIDTH-1:0] cnt_r;
  logic             adim_r;
  logic             tc_r;

  logic             step_s;
  logic [WIDTH:0]   step_res_s;
  logic [PW-1:0]    presc_nxt_s;
  logic [WIDTH-1:0] cnt_nxt_s;
  logic             adim_nxt_s;
  logic             tc_nxt_s;

  // Step edge: enabled and the prescaler is on its last phase.
  always_comb begin
    step_s = en && (presc_cnt == PRESC_LAST);
  end

  // Candidate next count for a step in the currently requested direction.
  always_comb begin
    step_res_s = {1'b0, cnt_r};
    if (yon) begin
      step_res_s = step_up(cnt_r);
    end else begin
      step_res_s = step_down(cnt_r);
    end
  end

  // Next-state logic: load beats step, step beats plain prescaler advance.
  // Pulses default low so that a freeze or a load kills any pending pulse.
  always_comb begin
    presc_nxt_s = presc_cnt;
    cnt_nxt_s   = cnt_r;
    adim_nxt_s  = 1'b0;
    tc_nxt_s    = 1'b0;
    if (load) begin
      cnt_nxt_s   = clamp_load(load_val);
      presc_nxt_s = PRESC_ZERO;
    end else if (step_s) begin
      cnt_nxt_s   = step_res_s[WIDTH-1:0];
      presc_nxt_s = PRESC_ZERO;
      adim_nxt_s  = 1'b1;
      tc_nxt_s    = step_res_s[WIDTH];
    end else if (en) begin
      presc_nxt_s = presc_cnt + PRESC_ONE;
    end else begin
      presc_nxt_s = presc_cnt;
      cnt_nxt_s   = cnt_r;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_cnt <= PRESC_ZERO;
      cnt_r     <= CNT_ZERO;
      adim_r    <= 1'b0;
      tc_r      <= 1'b0;
    end else begin
      presc_cnt <= presc_nxt_s;
      cnt_r     <= cnt_nxt_s;
      adim_r    <= adim_nxt_s;
      tc_r      <= tc_nxt_s;
    end
  end

  assign sayac_degeri = cnt_r;
  assign adim         = adim_r;
  assign tc           = tc_r;

`ifndef SYNTHESIS
  sayac_param_chk #(
    .WIDTH  (WIDTH),
    .MODULO (MODULO)
  ) u_chk (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .load         (load),
    .load_val     (load_val),
    .sayac_degeri (sayac_degeri),
    .adim         (adim),
    .tc           (tc)
  );
`endif

endmodule

// -----------------------------------------------------------------------------
// sayac_param_chk -- protocol assertions for sayac_param.
//
// Ports mirror the counter's observable interface (all inputs).
// -----------------------------------------------------------------------------
module sayac_param_chk #(
  parameter int WIDTH  = 4,
  parameter int MODULO = 16
) (
  input logic             clk,
  input logic             rst,
  input logic             en,
  input logic             load,
  input logic [WIDTH-1:0] load_val,
  input logic [WIDTH-1:0] sayac_degeri,
  input logic             adim,
  input logic             tc
);

  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULO);
  localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MODULO - 1);

  logic [WIDTH-1:0] clamp_s;

  // Expected result of a load of the current load_val.
  always_comb begin
    if ({1'b0, load_val} >= MOD_EXT) begin
      clamp_s = CNT_MAX;
    end else begin
      clamp_s = load_val;
    end
  end

  // Count never leaves 0..MODULO-1.
  a_range : assert property (@(posedge clk) sayac_degeri <= CNT_MAX);

  // A terminal-count pulse only ever accompanies a step pulse.
  a_tc_adim : assert property (@(posedge clk) tc |-> adim);

  // Reset clears everything on the following cycle.
  a_rst : assert property (@(posedge clk)
    rst |=> (sayac_degeri == {WIDTH{1'b0}}) && !adim && !tc);

  // A load produces the clamped value and no pulses.
  a_load : assert property (@(posedge clk)
    (load && !rst) |=> (sayac_degeri == $past(clamp_s)) && !adim && !tc);

  // A frozen cycle holds the value and emits no pulses.
  a_freeze : assert property (@(posedge clk)
    (!en && !load && !rst) |=> (sayac_degeri == $past(sayac_degeri)) && !adim && !tc);

endmodule

// File: tb/tb_sayac_param.sv
// -----------------------------------------------------------------------------
// tb_sayac_param -- self-checking bench for sayac_param with WIDTH=4,
// MODULO=10, PRESCALE=4. A table of per-edge {inputs, expected outputs}
// records is built first and then replayed, followed by a hand-written
// freeze / mid-interval reset sequence.
// -----------------------------------------------------------------------------
module tb_sayac_param;

  logic       clk;
  logic       rst;
  logic       en;
  logic       yon;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] sayac_degeri;
  logic       adim;
  logic       tc;

  int n_cmp;
  int n_bad;

  typedef struct {
    logic       rst;
    logic       en;
    logic       yon;
    logic       load;
    logic [3:0] lv;
    logic [3:0] cnt;
    logic       adim;
    logic       tc;
  } vec_t;

  vec_t vq[$];

  sayac_param #(
    .WIDTH    (4),
    .MODULO   (10),
    .PRESCALE (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .yon          (yon),
    .load         (load),
    .load_val     (load_val),
    .sayac_degeri (sayac_degeri),
    .adim         (adim),
    .tc           (tc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic r, input logic e, input logic y, input logic l,
                     input logic [3:0] lv, input logic [3:0] c,
                     input logic a, input logic t);
    vec_t v;
    v.rst = r; v.en = e; v.yon = y; v.load = l; v.lv = lv;
    v.cnt = c; v.adim = a; v.tc = t;
    vq.push_back(v);
  endtask

  // Drive one record, clock it in, and compare all three outputs.
  task automatic apply_one(input vec_t v, input int idx);
    rst = v.rst; en = v.en; yon = v.yon; load = v.load; load_val = v.lv;
    @(posedge clk);
    #1;
    n_cmp++;
    if (sayac_degeri !== v.cnt) begin
      n_bad++;
      $display("FAIL cnt vec %0d: got %0d expected %0d", idx, sayac_degeri, v.cnt);
    end
    n_cmp++;
    if (adim !== v.adim) begin
      n_bad++;
      $display("FAIL adim vec %0d: got %0b expected %0b", idx, adim, v.adim);
    end
    n_cmp++;
    if (tc !== v.tc) begin
      n_bad++;
      $display("FAIL tc vec %0d: got %0b expected %0b", idx, tc, v.tc);
    end
  endtask

  task automatic hand(input int idx, input logic r, input logic e, input logic y,
                      input logic [3:0] c, input logic a, input logic t);
    vec_t v;
    v.rst = r; v.en = e; v.yon = y; v.load = 1'b0; v.lv = 4'd0;
    v.cnt = c; v.adim = a; v.tc = t;
    apply_one(v, idx);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1; en = 1'b0; yon = 1'b1; load = 1'b0; load_val = 4'd0;

    // ---- table construction ----
    // Reset held 3 cycles with en and load high: load ignored.
    for (int i = 0; i < 3; i++) add(1'b1, 1'b1, 1'b1, 1'b1, 4'd5, 4'd0, 1'b0, 1'b0);

`ifdef SAYAC_SATURATE_EN
    // Saturate at top: load 9, two steps up stay at 9 with tc+adim.
    add(1'b0, 1'b1, 1'b1, 1'b1, 4'd9, 4'd9, 1'b0, 1'b0);
    for (int e = 1; e <= 8; e++)
      add(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd9, (e % 4) == 0, (e % 4) == 0);
    // Saturate at bottom.
    add(1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0);
    for (int e = 1; e <= 4; e++)
      add(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, e == 4, e == 4);
`else
    // Count up from reset: value k on edge 4k, wrap to 0 with tc at edge 40.
    for (int e = 1; e <= 40; e++)
      add(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'((e / 4) % 10), (e % 4) == 0, e == 40);
    // Count down from 0: 9 with tc, then 8 without.
    for (int e = 1; e <= 8; e++)
      add(1'b0, 1'b1, 1'b0, 1'b0, 4'd0,
          (e < 4) ? 4'd0 : ((e < 8) ? 4'd9 : 4'd8), (e % 4) == 0, e == 4);
`endif

    // Re-establish a known phase.
    add(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    // Load 7 at presc_cnt=2; next step 4 edges later gives 8.
    add(1'b0, 1'b1, 1'b1, 1'b1, 4'd7, 4'd7, 1'b0, 1'b0);
    for (int e = 1; e <= 4; e++)
      add(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, (e == 4) ? 4'd8 : 4'd7, e == 4, 1'b0);
    // Load 12 clamps to 9; then count down to 8.
    add(1'b0, 1'b1, 1'b1, 1'b1, 4'd12, 4'd9, 1'b0, 1'b0);
    for (int e = 1; e <= 4; e++)
      add(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, (e == 4) ? 4'd8 : 4'd9, e == 4, 1'b0);
    // Load on a step edge (presc_cnt=3): loaded value, no adim.
    for (int e = 1; e <= 3; e++)
      add(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd8, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b1, 4'd3, 4'd3, 1'b0, 1'b0);
    for (int e = 1; e <= 4; e++)
      add(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, (e == 4) ? 4'd4 : 4'd3, e == 4, 1'b0);

    // ---- replay ----
    @(negedge clk);
    for (int i = 0; i < vq.size(); i++) apply_one(vq[i], i);

    // ---- hand-written: freeze and mid-interval reset (value 4, phase 0) ----
    hand(1000, 1'b0, 1'b1, 1'b1, 4'd4, 1'b0, 1'b0);           // phase -> 1
    for (int i = 0; i < 10; i++)
      hand(1001 + i, 1'b0, 1'b0, 1'b1, 4'd4, 1'b0, 1'b0);     // frozen
    hand(1020, 1'b0, 1'b1, 1'b1, 4'd4, 1'b0, 1'b0);           // phase -> 2
    hand(1021, 1'b0, 1'b1, 1'b1, 4'd4, 1'b0, 1'b0);           // phase -> 3
    hand(1022, 1'b0, 1'b1, 1'b1, 4'd5, 1'b1, 1'b0);           // step 3 edges later
    hand(1023, 1'b0, 1'b1, 1'b1, 4'd5, 1'b0, 1'b0);           // phase -> 1
    hand(1024, 1'b1, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0);           // reset mid-interval
    hand(1025, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
    hand(1026, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
    hand(1027, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
    hand(1028, 1'b0, 1'b1, 1'b1, 4'd1, 1'b1, 1'b0);           // first step, 4th edge
    hand(1029, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0);           // freeze drops pulse

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sayac_param.md
# sayac_param

Parametrised up/down counter with a built-in clock-enable prescaler, replacing the fixed 4-bit counter clocked from a divided clock. The whole block runs on the board clock. The prescaler generates a one-cycle step enable. The counter has configurable width and modulus, synchronous load, enable, and a terminal-count pulse. Outputs drive the 7-segment/LED display logic directly.

## Interface
- `WIDTH`, 4: counter width in bits.
- `MODULO`, 16: count range is 0..MODULO-1. Legal range is 2 ≤ MODULO ≤ 2^WIDTH.
- `PRESCALE`, 50_000_000: clk cycles per count step. Must be ≥ 1; 1 means a step on every clk edge.
- `clk`, input, 1: system clock. All logic is on its rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `en`, input, 1: 1 runs prescaler and counter; 0 freezes both.
- `yon`, input, 1: direction. 1 = up, 0 = down. Sampled only on step edges.
- `load`, input, 1: synchronous load strobe.
- `load_val`, input, WIDTH: value to load.
- `sayac_degeri`, output, WIDTH: current count, registered.
- `adim`, output, 1: registered one-cycle pulse after every count step.
- `tc`, output, 1: registered one-cycle pulse after a wrap step (or a saturate step, see Configuration).

## Operation
- Internal prescaler `presc_cnt` has width $clog2(PRESCALE) (minimum 1). It counts 0..PRESCALE-1 while `en`=1.
- A step edge is a clk edge with `en`=1 and `presc_cnt`==PRESCALE-1. On that edge `presc_cnt` returns to 0.
- Priority on each edge, highest first: `rst`, then `load`, then step, then hold.
- `rst`: `sayac_degeri`=0, `presc_cnt`=0, `adim`=0, `tc`=0.
- `load` (independent of `en`):
  - `sayac_degeri` = `load_val`. If `load_val` ≥ MODULO, it is clamped to MODULO-1.
  - `presc_cnt`=0, `adim`=0, `tc`=0.
  - A load coinciding with a step edge suppresses that step.
- Step, up (`yon`=1): MODULO-1 → 0 with `tc`=1. Otherwise +1.
- Step, down (`yon`=0): 0 → MODULO-1 with `tc`=1. Otherwise -1.
- Every step sets `adim`=1 for exactly one cycle. `tc`=0 on non-wrapping steps.
- `en`=0: `sayac_degeri` and `presc_cnt` hold. `adim`=0 and `tc`=0.
- Arithmetic is done in WIDTH+1 bits, so MODULO=2^WIDTH wraps without overflow artefacts.

## Timing
- After `rst` release with `en`=1: first step at the PRESCALE-th rising edge. Steps then recur every PRESCALE edges.
- `sayac_degeri`, `adim` and `tc` all update on the step edge itself. Latency from step edge to output is 0 cycles; each is a registered output.
- `yon` change between steps takes effect at the next step edge. There is no glitching mid-interval.
- `load`: value is visible the edge after `load` is sampled high. The next step is PRESCALE edges later.
- `rst` mid-interval or mid-pulse: all state clears on that edge, including any pending `tc`/`adim`.
- PRESCALE=1: `adim` stays high continuously while `en`=1. `tc` is high on each wrap cycle only.

## Configuration
- `SAYAC_SATURATE_EN` defined: saturating mode.
  - Up at MODULO-1 holds at MODULO-1. Down at 0 holds at 0.
  - `tc` pulses on every step that hits a limit (attempted overflow).
  - `adim` still pulses on every step.
- `SAYAC_SATURATE_EN` undefined: modulo wrap as described in Operation.

## Test plan
All tests use WIDTH=4, MODULO=10, PRESCALE=4.
1. Reset: hold `rst` 3 cycles with `en`=1, `load`=1 → `sayac_degeri`=0, `adim`=0, `tc`=0. The `load` is ignored.
2. Count up with wrap: `en`=1, `yon`=1 from reset → values 1,2,…,9 on edges 4,8,…,36. Edge 40 → 0 with a single-cycle `tc`. `adim` pulses on each step edge only.
3. Count down with wrap: from 0 with `yon`=0 → next step gives 9 with `tc`=1. The following step gives 8 with `tc`=0.
4. Load and clamp:
   - `load_val`=7 at `presc_cnt`=2 → `sayac_degeri`=7. Next step lands 4 edges later and gives 8.
   - `load_val`=12 → 9.
   - `load` on a step edge → loaded value, no `adim`.
5. Freeze and reset mid-run: drop `en` for 10 cycles at `presc_cnt`=1 → value and phase hold. After re-enable, the step comes 3 edges later. `rst` asserted mid-interval → 0, and the first step is 4 edges after release.
6. Saturate (`SAYAC_SATURATE_EN`): at 9 with `yon`=1 → stays 9, with `tc` and `adim` pulsing every 4 edges. At 0 with `yon`=0 → stays 0, with `tc` pulsing.
